// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: registered 2-cycle multiply, 32-step restoring divide.
// Holds the destination tag across the op and emits a one-cycle done strobe with the result.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      mulDiv_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            we_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we_out
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t            r_state;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_a, r_b;
  logic [2*XLEN-1:0] r_rq;
  logic [4:0]        r_cnt;
  logic              r_neg_q, r_neg_r, r_we;
  logic              r_done, r_we_out;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_out;

  logic              w_accept, w_is_div, w_sgn_div, w_a_neg, w_b_neg, w_div0, w_ovf;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_spec;
  logic              w_sa, w_sb;
  logic [2*XLEN-1:0] w_ma, w_mb, w_prod, w_sh;
  logic [XLEN-1:0]   w_mul_res, w_q, w_r;
  logic [XLEN:0]     w_diff;

  assign busy   = (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX);
  assign done   = r_done;
  assign result = r_result;
  assign rd_out = r_rd_out;
  assign we_out = r_we_out;

  assign w_accept  = start && !flush && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_is_div  = mulDiv_op[2];
  assign w_sgn_div = w_is_div && !mulDiv_op[0];
  assign w_a_neg   = w_sgn_div && op_a[XLEN-1];
  assign w_b_neg   = w_sgn_div && op_b[XLEN-1];
  assign w_a_mag   = w_a_neg ? -op_a : op_a;
  assign w_b_mag   = w_b_neg ? -op_b : op_b;
  assign w_div0    = (op_b == '0);
  assign w_ovf     = w_sgn_div && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  // Remainder ops (bit 1 set) take the dividend/zero, quotient ops the all-ones/min-int value.
  assign w_spec    = mulDiv_op[1] ? (w_div0 ? op_a : '0)
                                  : (w_div0 ? '1 : {1'b1, {(XLEN-1){1'b0}}});

  // Sign-extend into a double-width multiply; the low 2*XLEN bits equal the 33x33 signed product.
  assign w_sa      = ((r_op == 3'd1) || (r_op == 3'd2)) && r_a[XLEN-1];
  assign w_sb      = (r_op == 3'd1) && r_b[XLEN-1];
  assign w_ma      = {{XLEN{w_sa}}, r_a};
  assign w_mb      = {{XLEN{w_sb}}, r_b};
  assign w_prod    = w_ma * w_mb;
  assign w_mul_res = (r_op == 3'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  assign w_sh   = {r_rq[2*XLEN-2:0], 1'b0};
  assign w_diff = {1'b0, w_sh[2*XLEN-1:XLEN]} - {1'b0, r_b};
  assign w_q    = r_neg_q ? -r_rq[XLEN-1:0] : r_rq[XLEN-1:0];
  assign w_r    = r_neg_r ? -r_rq[2*XLEN-1:XLEN] : r_rq[2*XLEN-1:XLEN];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rq     <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_we     <= 1'b0;
      r_done   <= 1'b0;
      r_we_out <= 1'b0;
      r_result <= '0;
      r_rd_out <= '0;
    end else begin
      r_done   <= 1'b0;
      r_we_out <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_MUL: begin
            r_result <= w_mul_res;
            r_done   <= 1'b1;
            r_we_out <= r_we;
            r_state  <= S_DONE;
          end
          S_DIV: begin
            if (!w_diff[XLEN]) r_rq <= {w_diff[XLEN-1:0], r_rq[XLEN-2:0], 1'b1};
            else               r_rq <= w_sh;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) r_state <= S_FIX;
          end
          S_FIX: begin
            r_result <= r_op[1] ? w_r : w_q;
            r_done   <= 1'b1;
            r_we_out <= r_we;
            r_state  <= S_DONE;
          end
          default: begin
            if (w_accept) begin
              r_op     <= mulDiv_op;
              r_a      <= op_a;
              r_b      <= w_b_mag;
              r_we     <= we_in;
              r_rd_out <= rd_in;
              if (!w_is_div) begin
                r_state <= S_MUL;
              end else if (w_div0 || w_ovf) begin
                r_result <= w_spec;
                r_done   <= 1'b1;
                r_we_out <= we_in;
                r_state  <= S_DONE;
              end else begin
                r_rq    <= {{XLEN{1'b0}}, w_a_mag};
                r_cnt   <= '0;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                r_state <= S_DIV;
              end
            end else begin
              r_state <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed ops push expected results, a monitor pops on done.
module tb_muldiv_seq;
  localparam logic [2:0] O_MUL = 3'd0, O_MULH = 3'd1, O_MULHSU = 3'd2, O_MULHU = 3'd3,
                         O_DIV = 3'd4, O_DIVU = 3'd5, O_REM = 3'd6, O_REMU = 3'd7;

  logic        clk = 1'b0;
  logic        rst, start, flush, we_in;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [4:0]  rd;
  logic        busy, done, we_out;
  logic [31:0] result;
  logic [4:0]  rd_out;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_fail = 0;
  logic [31:0] last_res = 32'h0;

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .mulDiv_op(op), .op_a(a), .op_b(b),
    .rd_in(rd), .we_in(we_in), .flush(flush), .busy(busy), .done(done),
    .result(result), .rd_out(rd_out), .we_out(we_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", result, e.res);
          chk("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
          chk("we_out", {31'd0, we_out}, {31'd0, e.we});
          last_res = e.res;
        end
      end else if (we_out !== 1'b0) begin
        chk("we_out_idle", {31'd0, we_out}, 32'd0);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] r, input logic w, input logic [31:0] exp, input bit push);
    op = o; a = x; b = y; rd = r; we_in = w; start = 1'b1;
    if (push) q.push_back('{res: exp, rd: r, we: w});
  endtask

  // Step from cycle k0 until done; busy must be high exactly in cycles below lat.
  task automatic wait_from(input int k0, input int lat);
    int k;
    k = k0 + 1;
    while (k <= 60) begin
      @(negedge clk);
      chk($sformatf("busy_c%0d", k), {31'd0, busy}, {31'd0, (k < lat)});
      if (done) break;
      k++;
    end
    chk("latency", k, lat);
  endtask

  task automatic wait_done(input int lat);
    @(posedge clk); #1 start = 1'b0;
    wait_from(0, lat);
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [4:0] r, input logic w, input logic [31:0] exp, input int lat);
    issue(o, x, y, r, w, exp, 1'b1);
    wait_done(lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; we_in = 1'b0;
    op = '0; a = '0; b = '0; rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", {27'd0, rd_out}, 32'd0);
    chk("rst_we", {31'd0, we_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Multiply, then back-to-back MULH issued in the DONE cycle.
    run(O_MUL, 32'd7, 32'hFFFFFFFD, 5'd1, 1'b1, 32'hFFFFFFEB, 2);
    run(O_MULH, 32'h80000000, 32'h80000000, 5'd2, 1'b1, 32'h40000000, 2);
    run(O_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 1'b1, 32'hFFFFFFFE, 2);
    run(O_MULHSU, 32'hFFFFFFFF, 32'd2, 5'd4, 1'b1, 32'hFFFFFFFF, 2);

    // Normal divides.
    run(O_DIVU, 32'd100, 32'd7, 5'd17, 1'b1, 32'd14, 34);
    run(O_REMU, 32'd100, 32'd7, 5'd18, 1'b0, 32'd2, 34);
    run(O_DIV, 32'hFFFFFFF9, 32'd2, 5'd5, 1'b1, 32'hFFFFFFFD, 34);
    run(O_REM, 32'hFFFFFFF9, 32'd2, 5'd6, 1'b1, 32'hFFFFFFFF, 34);
    run(O_DIV, 32'd20, 32'hFFFFFFFD, 5'd7, 1'b1, 32'hFFFFFFFA, 34);
    run(O_REM, 32'd20, 32'hFFFFFFFD, 5'd8, 1'b1, 32'd2, 34);
    run(O_DIVU, 32'h80000000, 32'hFFFFFFFF, 5'd9, 1'b1, 32'd0, 34);

    // Special cases complete in one cycle.
    run(O_DIVU, 32'd5, 32'd0, 5'd10, 1'b1, 32'hFFFFFFFF, 1);
    run(O_REM, 32'd5, 32'd0, 5'd11, 1'b1, 32'd5, 1);
    run(O_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd12, 1'b1, 32'h80000000, 1);
    run(O_REM, 32'h80000000, 32'hFFFFFFFF, 5'd13, 1'b0, 32'd0, 1);

    // Flush mid-divide at cycle 10, then MUL issued in cycle 11.
    issue(O_DIV, 32'd1000, 32'd3, 5'd14, 1'b1, 32'd0, 1'b0);
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    chk("flush_result", result, last_res);
    run(O_MUL, 32'd3, 32'd4, 5'd15, 1'b1, 32'd12, 2);

    // Flush together with start: nothing accepted.
    issue(O_MUL, 32'd5, 32'd5, 5'd16, 1'b1, 32'd0, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("flush_start_done", {31'd0, done}, 32'd0);

    // Reset at cycle 20 of a divide.
    issue(O_DIVU, 32'd100, 32'd7, 5'd19, 1'b1, 32'd0, 1'b0);
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_result", result, 32'd0);
    chk("mrst_rd", {27'd0, rd_out}, 32'd0);
    chk("mrst_we", {31'd0, we_out}, 32'd0);
    repeat (40) @(negedge clk);

    // Start pulsed while busy is ignored; the divide completes unchanged.
    issue(O_DIVU, 32'd100, 32'd7, 5'd3, 1'b1, 32'd14, 1'b1);
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    issue(O_MUL, 32'd1, 32'd1, 5'd9, 1'b1, 32'd0, 1'b0);
    @(posedge clk); #1 start = 1'b0;
    wait_from(5, 34);

    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
